// File: rtl/softmc_pkg.sv
// Shared definitions for the instruction front end.
// - Default END opcode and width of the opcode field.
// - Position of the opcode field: it occupies the top OPC_W bits of each instruction word.
// - Receiver state encoding (IDLE=0, RECV=1).
package softmc_pkg;

  localparam int OPC_W_DEF = 4;

  // Opcode that closes an instruction sequence.
  localparam logic [OPC_W_DEF-1:0] END_ISEQ = 4'hF;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } router_state_t;

  // LSB index of the opcode field. The field is instr[instr_w-1 -: opc_w].
  function automatic int opc_lsb(input int instr_w, input int opc_w);
    return instr_w - opc_w;
  endfunction

endpackage

// File: rtl/instr_fifo_striper.sv
// Stripes accepted instruction words round-robin across NUM_FIFOS downstream FIFOs.
// The accepted word and its write flag are registered here, so writes appear one cycle
// after acceptance. The stripe pointer advances on every write and wraps after the last
// FIFO. It is forced back to FIFO 0 while clear (process_iseq) is high, so each new
// sequence starts at FIFO 0.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   wr         accepted word must be written (registered internally)
//   wr_data    accepted word (registered internally)
//   clear      forces the pointer to 0 for the next cycle
//   fifo_en    one-hot write strobe, fifo_data shared write data
module instr_fifo_striper #(
  parameter int NUM_FIFOS = 2,
  parameter int INSTR_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr,
  input  logic [INSTR_W-1:0]   wr_data,
  input  logic                 clear,
  output logic [NUM_FIFOS-1:0] fifo_en,
  output logic [INSTR_W-1:0]   fifo_data
);

  localparam int PTR_W = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1;

  logic [PTR_W-1:0]   ptr_reg, ptr_next;
  logic               wr_reg;
  logic [INSTR_W-1:0] data_reg;

  always_comb begin
    ptr_next = ptr_reg;
    if (clear) begin
      ptr_next = '0;
    end else if (wr_reg) begin
      if (ptr_reg == PTR_W'(NUM_FIFOS - 1)) begin
        ptr_next = '0;
      end else begin
        ptr_next = ptr_reg + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg  <= '0;
      wr_reg   <= 1'b0;
      data_reg <= '0;
    end else begin
      ptr_reg  <= ptr_next;
      wr_reg   <= wr;
      if (wr) begin
        data_reg <= wr_data;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FIFOS; gi++) begin : g_en
      assign fifo_en[gi] = wr_reg && (ptr_reg == PTR_W'(gi));
    end
  endgenerate

  assign fifo_data = data_reg;

endmodule

// File: rtl/instr_router_n.sv
// Instruction router. It accepts instruction sequences (Iseqs) from NUM_SRC requesters.
// Source 0 has the highest priority. The router grants one Iseq at a time and stripes its
// words across NUM_FIFOS dispatcher FIFOs. An Iseq closes on the END opcode. At that point
// the router pulses process_iseq (and process_iseq_host for host-type sources) and reports
// the source and the saturating word count.
// Ports:
//   clk, rst                           clock and synchronous active-high reset
//   dispatcher_ready, rdback_fifo_empty  gate the start of a new Iseq
//   src_en / src_ack / src_instr       per-source valid, consume strobe and packed words
//   fifo_en / fifo_data / fifo_full    downstream FIFO write port
//   process_iseq, process_iseq_host    one-cycle completion pulses
//   iseq_src, iseq_len, iseq_len_ovf   completion report
//   busy                               receiving an Iseq
module instr_router_n
  import softmc_pkg::*;
#(
  parameter int                 NUM_SRC      = 2,
  parameter int                 NUM_FIFOS    = 2,
  parameter int                 INSTR_W      = 32,
  parameter int                 OPC_W        = OPC_W_DEF,
  parameter logic [OPC_W-1:0]   END_OPC      = OPC_W'(END_ISEQ),
  parameter logic [NUM_SRC-1:0] FWD_END_MASK = NUM_SRC'(1),
  parameter logic [NUM_SRC-1:0] HOST_MASK    = NUM_SRC'(1),
  parameter int                 LEN_W        = 16,
  localparam int                SRC_W        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       dispatcher_ready,
  input  logic                       rdback_fifo_empty,
  input  logic [NUM_SRC-1:0]         src_en,
  output logic [NUM_SRC-1:0]         src_ack,
  input  logic [NUM_SRC*INSTR_W-1:0] src_instr,
  output logic [NUM_FIFOS-1:0]       fifo_en,
  output logic [INSTR_W-1:0]         fifo_data,
  input  logic [NUM_FIFOS-1:0]       fifo_full,
  output logic                       process_iseq,
  output logic                       process_iseq_host,
  output logic [SRC_W-1:0]           iseq_src,
  output logic [LEN_W-1:0]           iseq_len,
  output logic                       iseq_len_ovf,
  output logic                       busy
);

  localparam int OPC_LSB = opc_lsb(INSTR_W, OPC_W);

  router_state_t state_reg, state_next;
  logic [SRC_W-1:0] src_reg, src_next;
  logic             rdback_empty_reg;
  logic             proc_reg, host_reg;
  logic [LEN_W-1:0] cnt_reg, cnt_new, cnt_base;
  logic             ovf_reg, ovf_new, ovf_base;
  logic [LEN_W-1:0] len_reg;
  logic             len_ovf_reg;

  logic               any_full, start;
  logic               req_any;
  logic [SRC_W-1:0]   req_idx;
  logic [SRC_W-1:0]   cur_src;
  logic [INSTR_W-1:0] cur_word;
  logic               is_end, accept, grant, will_write;
  logic [INSTR_W-1:0] src_word [NUM_SRC];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_word
      assign src_word[gi] = src_instr[gi*INSTR_W +: INSTR_W];
    end
  endgenerate

  // Conservative back-pressure: any full FIFO stalls the whole router.
  assign any_full = |fifo_full;
  assign start    = dispatcher_ready & ~proc_reg & rdback_empty_reg & ~any_full;

  // Fixed-priority encoder. The loop runs downward, so the lowest requesting index wins.
  always_comb begin
    req_any = 1'b0;
    req_idx = '0;
    for (int s = NUM_SRC - 1; s >= 0; s--) begin
      if (src_en[s]) begin
        req_any = 1'b1;
        req_idx = SRC_W'(s);
      end
    end
  end

  // In IDLE the word under consideration is the grant word, which may itself be END.
  assign cur_src  = (state_reg == IDLE) ? req_idx : src_reg;
  assign cur_word = src_word[cur_src];
  assign is_end   = (cur_word[OPC_LSB +: OPC_W] == END_OPC);

  always_comb begin
    state_next = state_reg;
    src_next   = src_reg;
    src_ack    = '0;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start && req_any) begin
          src_ack[req_idx] = 1'b1;
          accept           = 1'b1;
          src_next         = req_idx;
          state_next       = RECV;
        end
      end
      RECV: begin
        src_ack[src_reg] = ~any_full;
        accept           = ~any_full & src_en[src_reg];
      end
      default: state_next = IDLE;
    endcase
    if (accept && is_end) begin
      state_next = IDLE;
    end
  end

  assign grant      = accept & (state_reg == IDLE);
  assign will_write = accept & (~is_end | FWD_END_MASK[cur_src]);

  // Count the words that will be written. The count restarts on grant and saturates.
  always_comb begin
    cnt_base = grant ? '0 : cnt_reg;
    ovf_base = grant ? 1'b0 : ovf_reg;
    cnt_new  = cnt_base;
    ovf_new  = ovf_base;
    if (will_write) begin
      if (&cnt_base) begin
        ovf_new = 1'b1;
      end else begin
        cnt_new = cnt_base + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      src_reg          <= '0;
      rdback_empty_reg <= 1'b1;
      proc_reg         <= 1'b0;
      host_reg         <= 1'b0;
      cnt_reg          <= '0;
      ovf_reg          <= 1'b0;
      len_reg          <= '0;
      len_ovf_reg      <= 1'b0;
    end else begin
      state_reg        <= state_next;
      src_reg          <= src_next;
      rdback_empty_reg <= rdback_fifo_empty;
      proc_reg         <= accept & is_end;
      host_reg         <= accept & is_end & HOST_MASK[cur_src];
      if (accept) begin
        cnt_reg <= cnt_new;
        ovf_reg <= ovf_new;
      end
      if (accept && is_end) begin
        len_reg     <= cnt_new;
        len_ovf_reg <= ovf_new;
      end
    end
  end

  instr_fifo_striper #(
    .NUM_FIFOS (NUM_FIFOS),
    .INSTR_W   (INSTR_W)
  ) u_striper (
    .clk       (clk),
    .rst       (rst),
    .wr        (will_write),
    .wr_data   (cur_word),
    .clear     (proc_reg),
    .fifo_en   (fifo_en),
    .fifo_data (fifo_data)
  );

  assign process_iseq      = proc_reg;
  assign process_iseq_host = host_reg;
  assign iseq_src          = src_reg;
  assign iseq_len          = len_reg;
  assign iseq_len_ovf      = len_ovf_reg;
  assign busy              = (state_reg != IDLE);

endmodule

// File: tb/tb_instr_router_n.sv
// Directed bench for instr_router_n.
// Instance dut_a uses the default parameters. Instance dut_b uses NUM_FIFOS=3 and LEN_W=2.
// Both instances share the same stimulus.
module tb_instr_router_n;

  logic        clk = 1'b0;
  logic        rst;
  logic        dispatcher_ready, rdback_fifo_empty;
  logic [1:0]  src_en;
  logic [63:0] src_instr;
  logic [1:0]  fifo_full;

  logic [1:0]  src_ack_a, fifo_en_a;
  logic [31:0] fifo_data_a;
  logic        proc_a, host_a, iseq_src_a, ovf_a, busy_a;
  logic [15:0] len_a;

  logic [1:0]  src_ack_b;
  logic [2:0]  fifo_en_b;
  logic [31:0] fifo_data_b;
  logic        proc_b, host_b, iseq_src_b, ovf_b, busy_b;
  logic [1:0]  len_b;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  instr_router_n dut_a (
    .clk(clk), .rst(rst), .dispatcher_ready(dispatcher_ready),
    .rdback_fifo_empty(rdback_fifo_empty), .src_en(src_en), .src_ack(src_ack_a),
    .src_instr(src_instr), .fifo_en(fifo_en_a), .fifo_data(fifo_data_a),
    .fifo_full(fifo_full), .process_iseq(proc_a), .process_iseq_host(host_a),
    .iseq_src(iseq_src_a), .iseq_len(len_a), .iseq_len_ovf(ovf_a), .busy(busy_a)
  );

  instr_router_n #(.NUM_FIFOS(3), .LEN_W(2)) dut_b (
    .clk(clk), .rst(rst), .dispatcher_ready(dispatcher_ready),
    .rdback_fifo_empty(rdback_fifo_empty), .src_en(src_en), .src_ack(src_ack_b),
    .src_instr(src_instr), .fifo_en(fifo_en_b), .fifo_data(fifo_data_b),
    .fifo_full({1'b0, fifo_full}), .process_iseq(proc_b), .process_iseq_host(host_b),
    .iseq_src(iseq_src_b), .iseq_len(len_b), .iseq_len_ovf(ovf_b), .busy(busy_b)
  );

  typedef struct {
    int          cyc;
    logic [2:0]  en;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int          cyc;
    logic        host;
    logic        src;
    logic [15:0] len;
    logic        ovf;
  } pr_t;

  wr_t wa[$];
  wr_t wb[$];
  pr_t pa[$];
  pr_t pb[$];

  // Capture FIFO writes and completion pulses on the falling edge.
  always @(negedge clk) begin
    if (fifo_en_a != 2'b00) wa.push_back('{cyc: cyc, en: {1'b0, fifo_en_a}, data: fifo_data_a});
    if (fifo_en_b != 3'b000) wb.push_back('{cyc: cyc, en: fifo_en_b, data: fifo_data_b});
    if (proc_a) pa.push_back('{cyc: cyc, host: host_a, src: iseq_src_a, len: len_a, ovf: ovf_a});
    if (proc_b) pb.push_back('{cyc: cyc, host: host_b, src: iseq_src_b, len: {14'd0, len_b}, ovf: ovf_b});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic clear_q();
    wa.delete(); wb.delete(); pa.delete(); pb.delete();
  endtask

  function automatic logic [31:0] word_of(input int s, input int k, input int nw);
    return (k < nw) ? {4'h1, 4'(s), 24'(k)} : {4'hF, 4'(s), 24'h0};
  endfunction

  task automatic chk_wa(input string tag, input int k, input logic [2:0] en, input logic [31:0] data);
    if (k < wa.size()) begin
      chk({tag, "_en"}, wa[k].en, en);
      chk({tag, "_data"}, wa[k].data, data);
    end else begin
      chk({tag, "_missing"}, wa.size(), k + 1);
    end
  endtask

  // Drive one Iseq per active source. Each cycle the task presents the current word,
  // samples the ack and advances that source's word index when the word was taken.
  // A stall can raise fifo_full[1] for stall_len cycles once source 0 reaches word stall_at.
  task automatic drive(input logic [1:0] act, input int nw0, input int nw1, input bit e0,
                       input bit e1, input int stall_at, input int stall_len,
                       output int acks_low, output int first1, output int last0);
    int idx[2];
    int tot[2];
    int nw[2];
    logic [1:0] acked;
    int stall_left;
    bit stall_done;
    bit pending;
    int t;
    idx[0] = 0; idx[1] = 0; nw[0] = nw0; nw[1] = nw1;
    tot[0] = nw0 + int'(e0); tot[1] = nw1 + int'(e1);
    acks_low = 0; first1 = -1; last0 = -1; stall_left = 0; stall_done = 0; t = 0;
    pending = 1'b1;
    while (pending && t < 400) begin
      for (int s = 0; s < 2; s++) begin
        src_en[s] = act[s] && (idx[s] < tot[s]);
        src_instr[s*32 +: 32] = word_of(s, idx[s], nw[s]);
      end
      if (!stall_done && act[0] && idx[0] == stall_at) begin
        stall_left = stall_len;
        stall_done = 1'b1;
      end
      fifo_full = (stall_left > 0) ? 2'b10 : 2'b00;
      #1;
      acked = src_ack_a & src_en;
      if (busy_a && src_en[0] && !src_ack_a[0]) acks_low++;
      tick();
      if (acked[0]) begin last0 = t; idx[0]++; end
      if (acked[1]) begin if (first1 < 0) first1 = t; idx[1]++; end
      if (stall_left > 0) stall_left--;
      t++;
      pending = (act[0] && idx[0] < tot[0]) || (act[1] && idx[1] < tot[1]);
    end
    src_en = '0;
    fifo_full = '0;
    chk("drive_done", 64'(pending), 64'd0);
  endtask

  int lo, f1, l0;

  initial begin
    rst = 1'b1; dispatcher_ready = 1'b1; rdback_fifo_empty = 1'b1;
    src_en = '0; src_instr = '0; fifo_full = '0;
    idle(3);
    $display("step reset");
    chk("rst_fifo_en", fifo_en_a, 0);
    chk("rst_fifo_data", fifo_data_a, 0);
    chk("rst_proc", proc_a, 0);
    chk("rst_host", host_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_len", len_a, 0);
    chk("rst_ovf", ovf_a, 0);
    chk("rst_src", iseq_src_a, 0);
    chk("rst_ack", src_ack_a, 0);
    rst = 1'b0;
    idle(2);

    // 1: host Iseq, 5 words + END
    $display("step 1 host iseq 5+END");
    clear_q();
    drive(2'b01, 5, 0, 1'b1, 1'b0, -1, 0, lo, f1, l0);
    idle(4);
    chk("t1_nwr", wa.size(), 6);
    for (int k = 0; k < 6; k++)
      chk_wa($sformatf("t1_w%0d", k), k, (k % 2 == 0) ? 3'b001 : 3'b010, word_of(0, k, 5));
    chk("t1_nproc", pa.size(), 1);
    if (pa.size() > 0) begin
      if (wa.size() > 5) chk("t1_proc_align", pa[0].cyc, wa[5].cyc);
      chk("t1_host", pa[0].host, 1);
      chk("t1_len", pa[0].len, 6);
      chk("t1_src", pa[0].src, 0);
      chk("t1_ovf", pa[0].ovf, 0);
    end

    // 2: maintenance Iseq, 3 words + END, END dropped
    $display("step 2 maint iseq 3+END");
    clear_q();
    drive(2'b10, 0, 3, 1'b0, 1'b1, -1, 0, lo, f1, l0);
    idle(4);
    chk("t2_nwr", wa.size(), 3);
    for (int k = 0; k < 3; k++)
      chk_wa($sformatf("t2_w%0d", k), k, (k % 2 == 0) ? 3'b001 : 3'b010, word_of(1, k, 3));
    chk("t2_nproc", pa.size(), 1);
    if (pa.size() > 0) begin
      if (wa.size() > 2) chk("t2_proc_cyc", pa[0].cyc, wa[2].cyc + 1);
      chk("t2_host", pa[0].host, 0);
      chk("t2_len", pa[0].len, 3);
      chk("t2_src", pa[0].src, 1);
    end

    // 3: simultaneous requests, source 0 first
    $display("step 3 simultaneous requests");
    clear_q();
    drive(2'b11, 2, 1, 1'b1, 1'b1, -1, 0, lo, f1, l0);
    idle(4);
    chk("t3_src1_grant_cycle", f1, l0 + 2);
    chk("t3_nwr", wa.size(), 4);
    chk_wa("t3_w0", 0, 3'b001, word_of(0, 0, 2));
    chk_wa("t3_w1", 1, 3'b010, word_of(0, 1, 2));
    chk_wa("t3_w2", 2, 3'b001, word_of(0, 2, 2));
    chk_wa("t3_w3", 3, 3'b001, word_of(1, 0, 1));
    chk("t3_nproc", pa.size(), 2);
    if (pa.size() > 1) begin
      chk("t3_p0_src", pa[0].src, 0);
      chk("t3_p0_len", pa[0].len, 3);
      chk("t3_p1_src", pa[1].src, 1);
      chk("t3_p1_len", pa[1].len, 1);
      chk("t3_p1_host", pa[1].host, 0);
    end

    // 4: fifo_full[1] for 4 cycles mid-Iseq
    $display("step 4 fifo full stall");
    clear_q();
    drive(2'b01, 6, 0, 1'b1, 1'b0, 2, 4, lo, f1, l0);
    idle(4);
    chk("t4_acks_low", lo, 4);
    chk("t4_nwr", wa.size(), 7);
    for (int k = 0; k < 7; k++)
      chk_wa($sformatf("t4_w%0d", k), k, (k % 2 == 0) ? 3'b001 : 3'b010, word_of(0, k, 6));
    chk("t4_nproc", pa.size(), 1);
    if (pa.size() > 0) chk("t4_len", pa[0].len, 7);

    // 5: start gating, then a single-word END Iseq
    $display("step 5 start gating");
    clear_q();
    dispatcher_ready = 1'b0; rdback_fifo_empty = 1'b0;
    src_en = 2'b01; src_instr[31:0] = word_of(0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1; chk($sformatf("t5_noready_ack%0d", i), src_ack_a, 0);
      tick();
    end
    dispatcher_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1; chk($sformatf("t5_nordback_ack%0d", i), src_ack_a, 0);
      tick();
    end
    chk("t5_busy", busy_a, 0);
    rdback_fifo_empty = 1'b1;
    #1; chk("t5_ack_early", src_ack_a, 0);
    tick();
    #1; chk("t5_ack_grant", src_ack_a, 2'b01);
    tick();
    src_en = '0;
    idle(4);
    chk("t5_nwr", wa.size(), 1);
    chk_wa("t5_w0", 0, 3'b001, word_of(0, 0, 0));
    chk("t5_nproc", pa.size(), 1);
    if (pa.size() > 0) begin
      chk("t5_len", pa[0].len, 1);
      chk("t5_host", pa[0].host, 1);
    end

    // 6: reset mid-Iseq, then 7 writes on the 3-FIFO / 2-bit-counter instance
    $display("step 6 reset mid-iseq and 3-fifo striping");
    clear_q();
    drive(2'b01, 3, 0, 1'b0, 1'b0, -1, 0, lo, f1, l0);
    idle(1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle(3);
    chk("t6_rst_busy", busy_a, 0);
    chk("t6_rst_no_proc_a", pa.size(), 0);
    chk("t6_rst_no_proc_b", pb.size(), 0);
    clear_q();
    drive(2'b01, 6, 0, 1'b1, 1'b0, -1, 0, lo, f1, l0);
    idle(4);
    chk("t6_b_nwr", wb.size(), 7);
    for (int k = 0; k < 7; k++) begin
      if (k < wb.size()) begin
        chk($sformatf("t6_b_w%0d_en", k), wb[k].en, 3'b001 << (k % 3));
        chk($sformatf("t6_b_w%0d_data", k), wb[k].data, word_of(0, k, 6));
      end
    end
    chk("t6_b_nproc", pb.size(), 1);
    if (pb.size() > 0) begin
      chk("t6_b_len", pb[0].len, 3);
      chk("t6_b_ovf", pb[0].ovf, 1);
    end
    chk("t6_a_nproc", pa.size(), 1);
    if (pa.size() > 0) begin
      chk("t6_a_len", pa[0].len, 7);
      chk("t6_a_ovf", pa[0].ovf, 0);
    end
    chk_wa("t6_a_w0", 0, 3'b001, word_of(0, 0, 6));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
